ir_burst_capture: RTL and testbench
===================================

Name: ir_burst_capture

Overview:
- IR receive-side counterpart to the carrier PWM transmitter.
- Takes the raw modulated photodiode signal and recovers the carrier half-period.
- Measures mark (carrier present) and space (carrier absent) durations in clock cycles.
- Emits each mark/space as an event over a valid/ready interface. Used to learn codes and to loop-back verify transmitted codes.

Parameters:
- WIDTH, 8, width of carrier half-period and gap-timeout values.
- DUR_WIDTH, 16, width of mark/space duration counters (saturating).

Ports:
- clock_in  input  1  clock
- reset_in  input  1  synchronous, active-high reset
- enable_in  input  1  capture runs when high
- ir_in  input  1  raw asynchronous IR input, carrier-modulated
- timeout_in  input  WIDTH  edge-gap cycles that end a mark; must be >= 2
- clear_overflow_in  input  1  clears sticky overflow flag
- event_valid_out  output  1  event available
- event_ready_in  input  1  consumer accepts event when high with valid
- event_mark_out  output  1  1 = mark event, 0 = space event
- event_duration_out  output  DUR_WIDTH  event duration in cycles
- carrier_compare_out  output  WIDTH  last carrier half-period minus 1 (directly loadable as PWM compare value)
- overflow_out  output  1  sticky: an event was dropped

Behaviour:
- Reset (synchronous, active-high): FSM to IDLE; all counters 0; all outputs 0.
- Input path: ir_in passes a 2-FF synchronizer, then a registered edge detect. "Edge" = synchronized level differs from its previous value (either polarity). Edge flag is 3 cycles after the ir_in transition.
- FSM states: IDLE, MARK, SPACE.
- IDLE:
  - Counters held at 0.
  - Edge -> MARK, dur = 0, gap = 0.
  - No leading-space event is emitted.
- MARK:
  - dur increments each cycle, saturating at all-ones.
  - gap increments each cycle.
  - On edge: last_dur <= dur; half <= gap; gap <= 0. Then carrier_compare_out <= half-1, truncated to WIDTH.
  - carrier_compare_out is not updated on the mark's first edge.
  - When gap == timeout_in with no edge that cycle: emit mark event with duration = last_dur, i.e. cycles from first to last edge. A single-edge mark gives 0. Then -> SPACE, with space counter = gap.
- SPACE:
  - Space counter increments each cycle, saturating.
  - On edge: emit space event with duration = cycles from last mark edge to this edge. Then -> MARK, dur = 0, gap = 0.
  - Space counter reaching all-ones: emit space event with duration all-ones (end of code), then -> IDLE.
- Event output:
  - Single registered slot. event_valid_out rises the cycle after the emitting condition.
  - Slot clears on valid && ready.
  - If a new event is emitted while valid && !ready: the new event is dropped, the slot is unchanged, and overflow_out <= 1.
  - If accept and new emit happen in the same cycle: the new event loads; no overflow.
- Overflow: sticky until clear_overflow_in. Set and clear in the same cycle: set wins.
- enable_in low:
  - FSM -> IDLE, counters cleared, no event emitted for a partial mark/space.
  - A pending event stays valid until accepted.
  - The synchronizer keeps running.
- Reset mid-event: pending event is discarded, event_valid_out = 0 next cycle.
- Duration arithmetic: unsigned, saturating, never wraps.

Decomposition:
- Package ir_capture_pkg holds:
  - state typedef (IDLE/MARK/SPACE)
  - default WIDTH/DUR_WIDTH constants
  - event struct {mark, duration}
- One sub-module, ir_edge_sync: 2-FF synchronizer plus edge-detect register, outputs level and edge pulse.

Test Plan:
- Mark: timeout 40; 10 ir_in toggles spaced 13 cycles -> one mark event, duration 117; carrier_compare_out = 12; event_valid 1 cycle after the timeout cycle.
- Space: after the above, next toggle 300 cycles after the last toggle -> mark event, then space event duration 300 (mark=0); FSM back in MARK.
- End of code: after a mark, no edges for 70000 cycles -> space event duration 65535, FSM IDLE; next toggle emits no space event, starts new mark.
- Backpressure: event_ready_in held 0 across two events -> first event held unchanged, overflow_out = 1; clear_overflow_in pulse -> 0; clear with a simultaneous drop -> stays 1.
- Enable drop: enable_in low mid-mark (after 5 edges) -> no mark event; IDLE; re-enable and toggle -> fresh mark, carrier_compare_out not updated on first edge.
- Reset mid-operation: reset_in pulsed while event_valid_out = 1 and FSM in SPACE -> all outputs 0 next cycle; FSM IDLE; single-edge burst then timeout -> mark duration 0.

Source files
------------

// File: rtl/ir_capture_pkg.sv
// Shared types and default sizes for the IR burst capture block.
package ir_capture_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DUR_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } state_t;

    typedef struct packed {
        logic                     mark;
        logic [DUR_WIDTH_DEF-1:0] duration;
    } ir_event_t;

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchronizer for the raw IR input followed by a registered
// any-polarity edge detect; the edge pulse lands 3 clocks after the input moves.
module ir_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_level,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_edge;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_edge <= r_sync ^ r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_edge  = r_edge;

endmodule

// File: rtl/ir_burst_capture.sv
// Measures IR mark/space durations and the carrier half-period, and hands
// each mark/space out through a single-entry valid/ready slot.
module ir_burst_capture
    import ir_capture_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DUR_WIDTH = DUR_WIDTH_DEF
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 enable_in,
    input  logic                 ir_in,
    input  logic [WIDTH-1:0]     timeout_in,
    input  logic                 clear_overflow_in,
    output logic                 event_valid_out,
    input  logic                 event_ready_in,
    output logic                 event_mark_out,
    output logic [DUR_WIDTH-1:0] event_duration_out,
    output logic [WIDTH-1:0]     carrier_compare_out,
    output logic                 overflow_out
);

    localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;
    localparam logic [DUR_WIDTH-1:0] DUR_ONE = DUR_WIDTH'(1);
    localparam logic [WIDTH-1:0]     GAP_MAX = '1;
    localparam logic [WIDTH-1:0]     GAP_ONE = WIDTH'(1);

    state_t               r_state, w_state_nx;
    logic [DUR_WIDTH-1:0] r_dur, w_dur_nx, w_dur_inc;
    logic [DUR_WIDTH-1:0] r_last_dur, w_last_dur_nx;
    logic [WIDTH-1:0]     r_gap, w_gap_nx, w_gap_inc;
    logic [WIDTH-1:0]     r_cmp, w_cmp_nx;
    logic                 w_emit, w_emit_mark;
    logic [DUR_WIDTH-1:0] w_emit_dur;
    logic                 r_valid, r_ev_mark, r_overflow;
    logic [DUR_WIDTH-1:0] r_ev_dur;
    logic                 w_edge, w_level_unused, w_accept;

    ir_edge_sync u_edge_sync (
        .i_clk   (clock_in),
        .i_rst   (reset_in),
        .i_async (ir_in),
        .o_level (w_level_unused),
        .o_edge  (w_edge)
    );

    assign w_dur_inc = (r_dur == DUR_MAX) ? r_dur : r_dur + DUR_ONE;
    assign w_gap_inc = (r_gap == GAP_MAX) ? r_gap : r_gap + GAP_ONE;
    assign w_accept  = r_valid & event_ready_in;

    // r_dur / r_gap hold elapsed cycles since their reference edge, so an
    // edge loads 1 for the following cycle and the captured values are exact.
    always_comb begin
        w_state_nx    = r_state;
        w_dur_nx      = r_dur;
        w_last_dur_nx = r_last_dur;
        w_gap_nx      = r_gap;
        w_cmp_nx      = r_cmp;
        w_emit        = 1'b0;
        w_emit_mark   = 1'b0;
        w_emit_dur    = '0;
        if (!enable_in) begin
            w_state_nx    = IDLE;
            w_dur_nx      = '0;
            w_last_dur_nx = '0;
            w_gap_nx      = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_dur_nx      = '0;
                    w_last_dur_nx = '0;
                    w_gap_nx      = '0;
                    if (w_edge) begin
                        w_state_nx = MARK;
                        w_dur_nx   = DUR_ONE;
                        w_gap_nx   = GAP_ONE;
                    end
                end
                MARK: begin
                    if (w_edge) begin
                        w_last_dur_nx = r_dur;
                        w_cmp_nx      = r_gap - GAP_ONE;
                        w_gap_nx      = GAP_ONE;
                        w_dur_nx      = w_dur_inc;
                    end else if (r_gap >= timeout_in) begin
                        w_emit      = 1'b1;
                        w_emit_mark = 1'b1;
                        w_emit_dur  = r_last_dur;
                        w_state_nx  = SPACE;
                        w_dur_nx    = DUR_WIDTH'(r_gap) + DUR_ONE;
                    end else begin
                        w_dur_nx = w_dur_inc;
                        w_gap_nx = w_gap_inc;
                    end
                end
                SPACE: begin
                    if (w_edge) begin
                        w_emit        = 1'b1;
                        w_emit_dur    = r_dur;
                        w_state_nx    = MARK;
                        w_dur_nx      = DUR_ONE;
                        w_gap_nx      = GAP_ONE;
                        w_last_dur_nx = '0;
                    end else if (r_dur == DUR_MAX) begin
                        w_emit     = 1'b1;
                        w_emit_dur = DUR_MAX;
                        w_state_nx = IDLE;
                        w_dur_nx   = '0;
                        w_gap_nx   = '0;
                    end else begin
                        w_dur_nx = w_dur_inc;
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state    <= IDLE;
            r_dur      <= '0;
            r_last_dur <= '0;
            r_gap      <= '0;
            r_cmp      <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_dur      <= w_dur_nx;
            r_last_dur <= w_last_dur_nx;
            r_gap      <= w_gap_nx;
            r_cmp      <= w_cmp_nx;
        end
    end

    // Single output slot: a held, unaccepted event wins over a new one.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_valid    <= 1'b0;
            r_ev_mark  <= 1'b0;
            r_ev_dur   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_emit && (!r_valid || w_accept)) begin
                r_valid   <= 1'b1;
                r_ev_mark <= w_emit_mark;
                r_ev_dur  <= w_emit_dur;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_emit && r_valid && !event_ready_in) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow_in) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign event_valid_out     = r_valid;
    assign event_mark_out      = r_ev_mark;
    assign event_duration_out  = r_ev_dur;
    assign carrier_compare_out = r_cmp;
    assign overflow_out        = r_overflow;

endmodule

// File: tb/tb_ir_burst_capture.sv
// Self-checking bench for ir_burst_capture: directed corner sequences, a
// table of single-burst vectors and randomized bursts against an edge-list model.
module tb_ir_burst_capture;
    import ir_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset_in, enable_in, ir_in, clear_overflow_in, event_ready_in;
    logic [7:0]  timeout_in;
    logic        event_valid_out, event_mark_out, overflow_out;
    logic [15:0] event_duration_out;
    logic [7:0]  carrier_compare_out;

    int total = 0;
    int bad   = 0;
    ir_event_t got_q[$];
    ir_event_t exp_q[$];

    typedef struct {
        int         n;
        int         sp;
        logic [7:0] t;
        int         exp_dur;
        logic [7:0] exp_cmp;
    } vec_t;
    vec_t vt[5];

    always #5 clk = ~clk;

    ir_burst_capture dut (
        .clock_in            (clk),
        .reset_in            (reset_in),
        .enable_in           (enable_in),
        .ir_in               (ir_in),
        .timeout_in          (timeout_in),
        .clear_overflow_in   (clear_overflow_in),
        .event_valid_out     (event_valid_out),
        .event_ready_in      (event_ready_in),
        .event_mark_out      (event_mark_out),
        .event_duration_out  (event_duration_out),
        .carrier_compare_out (carrier_compare_out),
        .overflow_out        (overflow_out)
    );

    always @(negedge clk)
        if (!reset_in && event_valid_out && event_ready_in)
            got_q.push_back('{mark: event_mark_out, duration: event_duration_out});

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic toggle_after(input int d);
        repeat (d) @(posedge clk);
        #1 ir_in = ~ir_in;
    endtask

    task automatic burst(input int n, input int sp);
        toggle_after(1);
        for (int i = 1; i < n; i++) toggle_after(sp);
    endtask

    task automatic go_idle();
        @(posedge clk); #1 enable_in = 1'b0;
        @(posedge clk); #1 enable_in = 1'b1;
    endtask

    task automatic expect_event(input string nm, input logic em, input int ed, input int budget);
        ir_event_t ev;
        int n = 0;
        while (got_q.size() == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (got_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: no event within %0d cycles, expected mark=%0d dur=%0d", nm, budget, em, ed);
        end else begin
            ev = got_q.pop_front();
            chk({nm, "_mark"}, 32'(ev.mark), 32'(em));
            chk({nm, "_dur"}, 32'(ev.duration), 32'(ed));
        end
    endtask

    initial begin
        int t, n, d, mlen;
        logic [7:0] mcmp;

        vt[0] = '{n: 10, sp: 13, t: 8'd40, exp_dur: 117, exp_cmp: 8'd12};
        vt[1] = '{n: 1,  sp: 0,  t: 8'd20, exp_dur: 0,   exp_cmp: 8'd12};
        vt[2] = '{n: 4,  sp: 2,  t: 8'd5,  exp_dur: 6,   exp_cmp: 8'd1};
        vt[3] = '{n: 3,  sp: 40, t: 8'd40, exp_dur: 80,  exp_cmp: 8'd39};
        vt[4] = '{n: 6,  sp: 7,  t: 8'd10, exp_dur: 35,  exp_cmp: 8'd6};

        reset_in = 1'b1; enable_in = 1'b1; ir_in = 1'b0; clear_overflow_in = 1'b0;
        event_ready_in = 1'b1; timeout_in = 8'd40;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(event_valid_out), 0);
        chk("rst_mark", 32'(event_mark_out), 0);
        chk("rst_dur", 32'(event_duration_out), 0);
        chk("rst_cmp", 32'(carrier_compare_out), 0);
        chk("rst_ovf", 32'(overflow_out), 0);
        @(posedge clk); #1 reset_in = 1'b0;

        // Mark with exact valid timing, then a 300-cycle space, then end of code.
        burst(10, 13);
        repeat (43) @(posedge clk);
        @(negedge clk);
        chk("mark_early_valid", 32'(event_valid_out), 0);
        @(negedge clk);
        chk("mark_valid", 32'(event_valid_out), 1);
        chk("mark_flag", 32'(event_mark_out), 1);
        chk("mark_dur", 32'(event_duration_out), 117);
        chk("mark_cmp", 32'(carrier_compare_out), 12);
        repeat (256) @(posedge clk);
        #1 ir_in = ~ir_in;
        expect_event("mark_q", 1'b1, 117, 10);
        expect_event("space300", 1'b0, 300, 20);
        expect_event("eoc_mark", 1'b1, 0, 60);
        expect_event("eoc_space", 1'b0, 65535, 70000);
        toggle_after(5);
        expect_event("eoc_new", 1'b1, 0, 60);
        chk("eoc_cmp", 32'(carrier_compare_out), 12);
        go_idle();

        for (int i = 0; i < 5; i++) begin
            timeout_in = vt[i].t;
            burst(vt[i].n, vt[i].sp);
            expect_event($sformatf("vec%0d", i), 1'b1, vt[i].exp_dur, 300);
            chk($sformatf("vec%0d_cmp", i), 32'(carrier_compare_out), 32'(vt[i].exp_cmp));
            go_idle();
        end

        // Backpressure and overflow handling.
        timeout_in = 8'd10;
        event_ready_in = 1'b0;
        burst(3, 5);
        repeat (18) @(posedge clk);
        toggle_after(32);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_ovf", 32'(overflow_out), 1);
        chk("bp_valid", 32'(event_valid_out), 1);
        chk("bp_mark", 32'(event_mark_out), 1);
        chk("bp_dur", 32'(event_duration_out), 10);
        repeat (20) @(posedge clk);
        #1 clear_overflow_in = 1'b1;
        @(posedge clk); #1 clear_overflow_in = 1'b0;
        @(negedge clk);
        chk("bp_clear", 32'(overflow_out), 0);
        toggle_after(1);
        repeat (3) @(posedge clk);
        #1 clear_overflow_in = 1'b1;
        @(posedge clk); #1 clear_overflow_in = 1'b0;
        @(negedge clk);
        chk("bp_set_wins", 32'(overflow_out), 1);
        chk("bp_held_dur", 32'(event_duration_out), 10);
        event_ready_in = 1'b1;
        expect_event("bp_release", 1'b1, 10, 5);
        go_idle();
        @(posedge clk); #1 clear_overflow_in = 1'b1;
        @(posedge clk); #1 clear_overflow_in = 1'b0;
        @(negedge clk);
        chk("bp_final_ovf", 32'(overflow_out), 0);
        chk("bp_no_extra", 32'(got_q.size()), 0);

        // Enable dropped mid-mark.
        timeout_in = 8'd40;
        burst(5, 13);
        repeat (5) @(posedge clk);
        #1 enable_in = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("en_no_event", 32'(got_q.size()), 0);
        chk("en_valid", 32'(event_valid_out), 0);
        @(posedge clk); #1 enable_in = 1'b1;
        toggle_after(2);
        expect_event("en_fresh", 1'b1, 0, 60);
        chk("en_cmp", 32'(carrier_compare_out), 12);
        go_idle();

        // Randomized bursts: expected events derived from the list of edge gaps.
        for (int r = 0; r < 2; r++) begin
            timeout_in = 8'($urandom_range(8, 30));
            t = int'(timeout_in);
            got_q.delete();
            exp_q.delete();
            mlen = 0;
            mcmp = 8'd0;
            toggle_after(1);
            for (int b = 0; b < 3; b++) begin
                n = int'($urandom_range(2, 6));
                for (int i = 1; i < n; i++) begin
                    d = int'($urandom_range(2, t));
                    toggle_after(d);
                    mlen += d;
                    mcmp = 8'(d - 1);
                end
                if (b < 2) begin
                    d = int'($urandom_range(t + 1, t + 300));
                    toggle_after(d);
                    exp_q.push_back('{mark: 1'b1, duration: 16'(mlen)});
                    exp_q.push_back('{mark: 1'b0, duration: 16'(d)});
                    mlen = 0;
                end
            end
            exp_q.push_back('{mark: 1'b1, duration: 16'(mlen)});
            repeat (t + 10) @(posedge clk);
            @(negedge clk);
            chk($sformatf("rnd%0d_count", r), 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                chk($sformatf("rnd%0d_ev%0d_mark", r, i), 32'(got_q[i].mark), 32'(exp_q[i].mark));
                chk($sformatf("rnd%0d_ev%0d_dur", r, i), 32'(got_q[i].duration), 32'(exp_q[i].duration));
            end
            chk($sformatf("rnd%0d_cmp", r), 32'(carrier_compare_out), 32'(mcmp));
            got_q.delete();
            go_idle();
        end

        // Reset while an event is pending and the FSM is in SPACE.
        enable_in = 1'b0;
        if (ir_in) toggle_after(1);
        repeat (5) @(posedge clk);
        #1 enable_in = 1'b1;
        timeout_in = 8'd10;
        event_ready_in = 1'b0;
        burst(4, 5);
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("rm_pre_valid", 32'(event_valid_out), 1);
        @(posedge clk); #1 reset_in = 1'b1;
        @(posedge clk); #1 reset_in = 1'b0;
        @(negedge clk);
        chk("rm_valid", 32'(event_valid_out), 0);
        chk("rm_mark", 32'(event_mark_out), 0);
        chk("rm_dur", 32'(event_duration_out), 0);
        chk("rm_cmp", 32'(carrier_compare_out), 0);
        chk("rm_ovf", 32'(overflow_out), 0);
        event_ready_in = 1'b1;
        toggle_after(2);
        expect_event("rm_single", 1'b1, 0, 40);
        chk("rm_cmp_after", 32'(carrier_compare_out), 0);
        repeat (5) @(posedge clk);
        chk("rm_no_space", 32'(got_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
